// File: rtl/dmi_responder.sv
// DMI responder on the debug-module side: one outstanding request, a small debug
// register set, modelled halt/resume control and abstract-command busy timing.
module dmi_responder #(
  parameter int unsigned CMD_LATENCY = 4,
  parameter int unsigned DM_VERSION  = 2,
  parameter int unsigned DATA_COUNT  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  input  logic [6:0]  dmi_req_addr_i,
  input  logic [1:0]  dmi_req_op_i,
  input  logic [31:0] dmi_req_data_i,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic [31:0] dmi_resp_data_o,
  output logic [1:0]  dmi_resp_code_o,
  output logic        halted_o,
  output logic        ndmreset_o,
  output logic        dmactive_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;
  localparam logic [1:0] CODE_OK  = 2'd0;
  localparam logic [1:0] CODE_ERR = 2'd2;

  localparam logic [6:0] A_DATA0      = 7'h04;
  localparam logic [6:0] A_DATA1      = 7'h05;
  localparam logic [6:0] A_DMCONTROL  = 7'h10;
  localparam logic [6:0] A_DMSTATUS   = 7'h11;
  localparam logic [6:0] A_ABSTRACTCS = 7'h16;
  localparam logic [6:0] A_COMMAND    = 7'h17;

  state_t      state_q, state_d;
  logic [6:0]  addr_q;
  logic [1:0]  op_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rcode_q, rcode_d;
  logic [31:0] data0_q, data0_d, data1_q, data1_d;
  logic        dmactive_q, dmactive_d, ndmreset_q, ndmreset_d;
  logic        halted_q, halted_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy, is_wr, new_err;

  assign busy  = (cnt_q != '0);
  assign is_wr = (op_q == OP_WRITE);

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    rcode_d    = rcode_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    dmactive_d = dmactive_q;
    ndmreset_d = ndmreset_q;
    halted_d   = halted_q;
    cmderr_d   = cmderr_q;
    cnt_d      = busy ? cnt_q - 8'd1 : '0;
    new_err    = 1'b0;
    case (state_q)
      IDLE: if (dmi_req_valid_i) state_d = ACCESS;
      ACCESS: begin
        state_d = RESP;
        rdata_d = '0;
        rcode_d = CODE_OK;
        if (op_q == OP_RSVD) begin
          rcode_d = CODE_ERR;
        end else if (op_q != OP_NOP && (dmactive_q || addr_q == A_DMCONTROL)) begin
          case (addr_q)
            A_DATA0:
              if (busy) new_err = 1'b1;
              else if (is_wr) data0_d = wdata_q;
              else rdata_d = data0_q;
            A_DATA1:
              if (busy) new_err = 1'b1;
              else if (is_wr) data1_d = wdata_q;
              else rdata_d = data1_q;
            A_DMCONTROL:
              if (is_wr) begin
                dmactive_d = wdata_q[0];
                ndmreset_d = wdata_q[1];
                if (wdata_q[31]) halted_d = 1'b1;
                else if (wdata_q[30]) halted_d = 1'b0;
              end else begin
                rdata_d = {30'b0, ndmreset_q, dmactive_q};
              end
            A_DMSTATUS:
              if (!is_wr)
                rdata_d = {20'b0, ~halted_q, ~halted_q, halted_q, halted_q,
                           1'b1, 3'b0, 4'(DM_VERSION)};
            A_ABSTRACTCS:
              if (is_wr) cmderr_d = cmderr_q & ~wdata_q[10:8];
              else rdata_d = {19'b0, busy, 1'b0, cmderr_q, 4'b0, 4'(DATA_COUNT)};
            A_COMMAND:
              if (is_wr) begin
                if (busy) new_err = 1'b1;
                else if (cmderr_q == '0) cnt_d = 8'(CMD_LATENCY);
              end
            default: rcode_d = CODE_ERR;
          endcase
        end
        // a busy violation overrides any W1C applied in the same access
        if (new_err && cmderr_q == '0) cmderr_d = 3'd1;
      end
      RESP: if (dmi_resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // an inactive debug module keeps its state cleared
    if (!dmactive_d) begin
      data0_d  = '0;
      data1_d  = '0;
      cmderr_d = '0;
      halted_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      op_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rcode_q    <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      dmactive_q <= 1'b0;
      ndmreset_q <= 1'b0;
      halted_q   <= 1'b0;
      cmderr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      rcode_q    <= rcode_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      dmactive_q <= dmactive_d;
      ndmreset_q <= ndmreset_d;
      halted_q   <= halted_d;
      cmderr_q   <= cmderr_d;
      cnt_q      <= cnt_d;
      if (state_q == IDLE && dmi_req_valid_i) begin
        addr_q  <= dmi_req_addr_i;
        op_q    <= dmi_req_op_i;
        wdata_q <= dmi_req_data_i;
      end
    end
  end

  assign dmi_req_ready_o  = (state_q == IDLE) && !rst_i;
  assign dmi_resp_valid_o = (state_q == RESP);
  assign dmi_resp_data_o  = rdata_q;
  assign dmi_resp_code_o  = rcode_q;
  assign halted_o         = halted_q;
  assign ndmreset_o       = ndmreset_q;
  assign dmactive_o       = dmactive_q;

endmodule
